// File: rtl/simple_rx.sv
// 8N1 UART receiver with a one-entry valid/ready output buffer.
// Optional SIMPLE_RX_MAJORITY_EN: 2-of-3 majority vote on every bit sample.
module simple_rx #(
  parameter int clocks_per_bit = 12
) (
  input  logic       _clock,
  input  logic       _reset,
  input  logic       _in,
  output logic [7:0] _out,
  output logic       _out_valid,
  input  logic       _out_ready,
  output logic       _frame_err,
  output logic       _overrun
);

  localparam logic [7:0] DELAY_MID  = 8'(clocks_per_bit / 2);
  localparam logic [7:0] DELAY_LAST = 8'(clocks_per_bit - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t     state, state_nxt;
  logic       s1, s2;
  logic [7:0] delay, delay_nxt;
  logic [7:0] shift, shift_nxt;
  logic [2:0] count, count_nxt;
  logic       armed, armed_nxt;
  logic       deliver, ferr;
  logic       sample;

  always_ff @(posedge _clock) begin
    if (_reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= _in;
      s2 <= s1;
    end
  end

`ifdef SIMPLE_RX_MAJORITY_EN
  // s2 one and two cycles back; together with s2 this spans the 3-cycle vote window
  logic [1:0] hist;

  always_ff @(posedge _clock) begin
    if (_reset) hist <= 2'b11;
    else        hist <= {hist[0], s2};
  end

  assign sample = (hist[1] & hist[0]) | (hist[1] & s2) | (hist[0] & s2);
`else
  assign sample = s2;
`endif

  always_ff @(posedge _clock) begin
    if (_reset) begin
      state <= IDLE;
      delay <= '0;
      count <= '0;
      shift <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      delay <= delay_nxt;
      count <= count_nxt;
      shift <= shift_nxt;
      armed <= armed_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    delay_nxt = delay;
    count_nxt = count;
    shift_nxt = shift;
    armed_nxt = armed;
    deliver   = 1'b0;
    ferr      = 1'b0;
    case (state)
      IDLE: begin
        // a start edge only counts once the line has been seen high
        if (s2) armed_nxt = 1'b1;
        if (armed && !s2) begin
          state_nxt = START;
          delay_nxt = '0;
          armed_nxt = 1'b0;
        end
      end
      START: begin
        delay_nxt = delay + 8'd1;
        if (delay == DELAY_MID) begin
          delay_nxt = '0;
          count_nxt = '0;
          state_nxt = sample ? IDLE : DATA;
        end
      end
      DATA: begin
        delay_nxt = delay + 8'd1;
        if (delay == DELAY_LAST) begin
          shift_nxt = {sample, shift[7:1]};
          delay_nxt = '0;
          count_nxt = count + 3'd1;
          if (count == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        delay_nxt = delay + 8'd1;
        if (delay == DELAY_LAST) begin
          delay_nxt = '0;
          state_nxt = IDLE;
          if (sample) deliver = 1'b1;
          else        ferr    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // holding buffer: an accept and a delivery on the same edge keeps it full
  always_ff @(posedge _clock) begin
    if (_reset) begin
      _out       <= '0;
      _out_valid <= 1'b0;
      _frame_err <= 1'b0;
      _overrun   <= 1'b0;
    end else begin
      _frame_err <= ferr;
      _overrun   <= deliver && _out_valid && !_out_ready;
      if (deliver && (!_out_valid || _out_ready)) begin
        _out       <= shift;
        _out_valid <= 1'b1;
      end else if (_out_valid && _out_ready) begin
        _out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_simple_rx.sv
// Directed bench for simple_rx: latency, back-to-back frames, glitch, framing error, overrun.
module tb_simple_rx;

  localparam int CPB = 12;
  localparam int MID = CPB / 2;

  logic       _clock = 1'b0;
  logic       _reset = 1'b1;
  logic       _in = 1'b1;
  logic       _out_ready = 1'b1;
  logic [7:0] _out;
  logic       _out_valid;
  logic       _frame_err;
  logic       _overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_start = 0;

  int   rises = 0;
  int   ferr_cnt = 0;
  int   ovr_cnt = 0;
  int   rx_cnt = 0;
  int   last_rise = 0;
  logic prev_valid = 1'b0;
  logic [7:0] rx_log [64];

  always #5 _clock = ~_clock;

  simple_rx #(.clocks_per_bit(CPB)) dut (
    ._clock    (_clock),
    ._reset    (_reset),
    ._in       (_in),
    ._out      (_out),
    ._out_valid(_out_valid),
    ._out_ready(_out_ready),
    ._frame_err(_frame_err),
    ._overrun  (_overrun)
  );

  always @(posedge _clock) cyc <= cyc + 1;

  // observe outputs half a cycle away from the active edge
  always @(negedge _clock) begin
    prev_valid <= _out_valid;
    if (_out_valid && !prev_valid) begin
      last_rise <= cyc;
      rises     <= rises + 1;
    end
    if (_out_valid && _out_ready) begin
      rx_log[rx_cnt % 64] <= _out;
      rx_cnt              <= rx_cnt + 1;
    end
    if (_frame_err) ferr_cnt <= ferr_cnt + 1;
    if (_overrun)   ovr_cnt  <= ovr_cnt + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge _clock);
    #1;
  endtask

  // one 8N1 frame; glitch_bit >= 0 pulls that data bit low for one cycle at its sample point
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int glitch_bit);
    logic v;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < CPB; j++) begin
        @(posedge _clock);
        #1;
        if (i == 0)      v = 1'b0;
        else if (i == 9) v = stop_v;
        else             v = b[i-1];
        if (i - 1 == glitch_bit && j == MID + 1) v = 1'b0;
        if (i == 0 && j == 0) t_start = cyc;
        _in = v;
      end
    end
  endtask

  initial begin
    int r0, f0, o0, v0;
    int exp_glitch;

    idle(3);
    _reset = 1'b0;
    idle(2);
    chk("rst_valid", _out_valid, 0);
    chk("rst_out",   _out, 0);
    chk("rst_ferr",  _frame_err, 0);
    chk("rst_ovr",   _overrun, 0);

    // single byte, latency from first low sample
    r0 = rx_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'hA5, 1'b1, -1);
    idle(10);
    chk("a5_latency", last_rise - t_start, 118);
    chk("a5_count",   rx_cnt - r0, 1);
    chk("a5_data",    rx_log[r0 % 64], 'hA5);
    chk("a5_ferr",    ferr_cnt - f0, 0);
    chk("a5_ovr",     ovr_cnt - o0, 0);

    // back-to-back frames
    r0 = rx_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    idle(10);
    chk("b2b_count", rx_cnt - r0, 2);
    chk("b2b_first", rx_log[r0 % 64], 'h00);
    chk("b2b_second", rx_log[(r0 + 1) % 64], 'hFF);
    chk("b2b_ferr",  ferr_cnt - f0, 0);
    chk("b2b_ovr",   ovr_cnt - o0, 0);

    // short low glitch while idle
    v0 = rises; f0 = ferr_cnt;
    _in = 1'b0;
    idle(3);
    _in = 1'b1;
    idle(40);
    chk("glitch_valid", rises - v0, 0);
    chk("glitch_ferr",  ferr_cnt - f0, 0);

    // low stop bit followed by a break, then recovery
    v0 = rises; f0 = ferr_cnt; r0 = rx_cnt;
    send_frame(8'h3C, 1'b0, -1);
    idle(100);
    chk("brk_ferr",  ferr_cnt - f0, 1);
    chk("brk_valid", rises - v0, 0);
    _in = 1'b1;
    idle(30);
    send_frame(8'h11, 1'b1, -1);
    idle(10);
    chk("brk_recover_count", rx_cnt - r0, 1);
    chk("brk_recover_data",  rx_log[r0 % 64], 'h11);
    chk("brk_ferr_total",    ferr_cnt - f0, 1);

    // overrun while consumer stalls
    r0 = rx_cnt; o0 = ovr_cnt;
    _out_ready = 1'b0;
    send_frame(8'h12, 1'b1, -1);
    send_frame(8'h34, 1'b1, -1);
    idle(5);
    chk("ovr_out",   _out, 'h12);
    chk("ovr_valid", _out_valid, 1);
    chk("ovr_pulse", ovr_cnt - o0, 1);
    chk("ovr_none_taken", rx_cnt - r0, 0);
    _out_ready = 1'b1;
    idle(3);
    chk("ovr_drain_valid", _out_valid, 0);
    chk("ovr_drain_count", rx_cnt - r0, 1);
    chk("ovr_drain_data",  rx_log[r0 % 64], 'h12);

    // one-cycle glitch at the sample point of data bit 3
    r0 = rx_cnt;
`ifdef SIMPLE_RX_MAJORITY_EN
    exp_glitch = 'hFF;
`else
    exp_glitch = 'hF7;
`endif
    send_frame(8'hFF, 1'b1, 3);
    idle(10);
    chk("maj_count", rx_cnt - r0, 1);
    chk("maj_data",  rx_log[r0 % 64], exp_glitch);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
